// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register: req/ack fetch from
// instruction memory, hazard freeze with a one-entry skid buffer, branch redirect.
//
//   state   | meaning
//   FETCH   | request outstanding at req_addr (idle for one cycle after reset)
//   HOLD    | fetched word parked in skid buffer while decode is frozen
//   DISCARD | stale request still in flight; drop its data, then go to target_q
module if_fetch_unit #(
    parameter int unsigned           WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [WORD_WIDTH-1:0] NOP_INSTR  = 32'hE1A00000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [WORD_WIDTH-1:0] branch_address,
    output logic                  imem_req,
    output logic [WORD_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [WORD_WIDTH-1:0] imem_rdata,
    output logic [WORD_WIDTH-1:0] pc_out,
    output logic [WORD_WIDTH-1:0] instruction_out,
    output logic                  valid_out
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [WORD_WIDTH-1:0] PC_STEP = WORD_WIDTH'(4);

    state_t                state;
    logic [WORD_WIDTH-1:0] req_addr;
    logic [WORD_WIDTH-1:0] target_q;
    logic [WORD_WIDTH-1:0] skid_pc;
    logic [WORD_WIDTH-1:0] skid_instr;
    logic [WORD_WIDTH-1:0] redirect;
    logic [WORD_WIDTH-1:0] next_pc;
    logic                  ack;

    // An ack only counts while our own request is up; late acks after reset are ignored.
    assign ack       = imem_ack & imem_req;
    assign redirect  = {branch_address[WORD_WIDTH-1:2], 2'b00};
    assign next_pc   = req_addr + PC_STEP;
    assign imem_addr = req_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= FETCH;
            imem_req        <= 1'b0;
            req_addr        <= RESET_PC;
            target_q        <= RESET_PC;
            skid_pc         <= '0;
            skid_instr      <= '0;
            pc_out          <= '0;
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
        end else if (branch_taken) begin
            pc_out          <= '0;
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
            imem_req        <= 1'b1;
            // A request still waiting for ack must keep its address until it completes.
            if (imem_req && !ack) begin
                target_q <= redirect;
                state    <= DISCARD;
            end else begin
                req_addr <= redirect;
                state    <= FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    imem_req <= 1'b1;
                    if (ack) begin
                        req_addr <= next_pc;
                        if (freeze) begin
                            skid_pc    <= next_pc;
                            skid_instr <= imem_rdata;
                            imem_req   <= 1'b0;
                            state      <= HOLD;
                        end else begin
                            pc_out          <= next_pc;
                            instruction_out <= imem_rdata;
                            valid_out       <= 1'b1;
                        end
                    end else if (!freeze) begin
                        pc_out          <= '0;
                        instruction_out <= NOP_INSTR;
                        valid_out       <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        pc_out          <= skid_pc;
                        instruction_out <= skid_instr;
                        valid_out       <= 1'b1;
                        imem_req        <= 1'b1;
                        state           <= FETCH;
                    end
                end
                DISCARD: begin
                    imem_req <= 1'b1;
                    if (ack) begin
                        req_addr <= target_q;
                        state    <= FETCH;
                    end
                end
                default: begin
                    imem_req <= 1'b1;
                    state    <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: address-echo memory with per-address latency,
// a transaction-level reference model compared every cycle, and directed scenarios.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'hE1A00000;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    int errors = 0;
    int checks = 0;

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .pc_out         (pc_out),
        .instruction_out(instruction_out),
        .valid_out      (valid_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory: data = address; the word at lat_addr takes lat_val extra cycles.
    logic [31:0] lat_addr;
    int          lat_val;
    int          waited;
    bit          prev_req;
    bit          prev_ack;

    function automatic int lat_of(input logic [31:0] a);
        return (a == lat_addr) ? lat_val : 0;
    endfunction

    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        waited     = 0;
        prev_req   = 1'b0;
        prev_ack   = 1'b0;
        forever begin
            @(posedge clk or negedge rst);
            #1;
            if (!rst) begin
                waited   = 0;
                prev_req = 1'b0;
                prev_ack = 1'b0;
                imem_ack = 1'b0;
            end else begin
                if (imem_req && prev_req && !prev_ack) waited++;
                else waited = 0;
                imem_ack   = imem_req && (waited >= lat_of(imem_addr));
                imem_rdata = imem_addr;
                prev_req   = imem_req;
                prev_ack   = imem_ack;
            end
        end
    end

    // Reference model: next fetch address, an optional parked word, and a
    // pending redirect that waits for the in-flight request to complete.
    logic [31:0] m_addr, m_pc, m_instr, m_redirect, s_pc, s_instr, tgt;
    bit          m_req, m_valid, m_stalled, m_drop, got;

    task automatic model_reset();
        m_req = 0; m_addr = 32'h0; m_pc = 32'h0; m_instr = NOP; m_valid = 0;
        m_stalled = 0; m_drop = 0; m_redirect = 32'h0; s_pc = 32'h0; s_instr = 32'h0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                model_reset();
            end else begin
                got = imem_ack && m_req;
                if (branch_taken) begin
                    tgt = branch_address & 32'hFFFF_FFFC;
                    m_pc = 32'h0; m_instr = NOP; m_valid = 0;
                    if (m_req && !got) begin
                        m_drop = 1; m_redirect = tgt;
                    end else begin
                        m_addr = tgt; m_drop = 0; m_stalled = 0;
                    end
                    m_req = 1;
                end else if (m_stalled) begin
                    if (!freeze) begin
                        m_pc = s_pc; m_instr = s_instr; m_valid = 1;
                        m_stalled = 0; m_req = 1;
                    end
                end else if (m_drop) begin
                    if (got) begin
                        m_addr = m_redirect; m_drop = 0;
                    end
                end else begin
                    m_req = 1;
                    if (got && freeze) begin
                        s_pc = m_addr + 32'd4; s_instr = imem_rdata;
                        m_addr = m_addr + 32'd4; m_stalled = 1; m_req = 0;
                    end else if (got) begin
                        m_pc = m_addr + 32'd4; m_instr = imem_rdata; m_valid = 1;
                        m_addr = m_addr + 32'd4;
                    end else if (!freeze) begin
                        m_pc = 32'h0; m_instr = NOP; m_valid = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model imem_req", 32'(imem_req), 32'(m_req));
            chk("model imem_addr", imem_addr, m_addr);
            chk("model pc_out", pc_out, m_pc);
            chk("model instruction_out", instruction_out, m_instr);
            chk("model valid_out", 32'(valid_out), 32'(m_valid));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string name, input logic [31:0] pc, input logic [31:0] ins,
                            input logic v);
        chk({name, " pc_out"}, pc_out, pc);
        chk({name, " instruction_out"}, instruction_out, ins);
        chk({name, " valid_out"}, 32'(valid_out), 32'(v));
    endtask

    task automatic chk_reset_vals(input string name);
        chk({name, " imem_req"}, 32'(imem_req), 32'h0);
        chk({name, " imem_addr"}, imem_addr, 32'h0);
        chk_ifid(name, 32'h0, NOP, 1'b0);
    endtask

    initial begin
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_address = '0;
        lat_addr = 32'h8; lat_val = 3;
        step(2);
        chk_reset_vals("reset");
        rst = 1'b1;

        // zero-wait stream, then 3-cycle wait at address 8
        step(1);
        chk("t1 req", 32'(imem_req), 32'h1);
        chk("t1 addr0", imem_addr, 32'h0);
        step(1);
        chk_ifid("t1 i0", 32'h4, 32'h0, 1'b1);
        chk("t1 addr4", imem_addr, 32'h4);
        step(1);
        chk_ifid("t1 i4", 32'h8, 32'h4, 1'b1);
        chk("t1 addr8", imem_addr, 32'h8);
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk_ifid("t2 bubble", 32'h0, NOP, 1'b0);
            chk("t2 addr held", imem_addr, 32'h8);
        end
        step(1);
        chk_ifid("t2 i8", 32'hC, 32'h8, 1'b1);
        chk("t2 addr12", imem_addr, 32'hC);

        // freeze for 4 cycles across the ack at 12
        freeze = 1'b1;
        step(1);
        chk("t3 req low", 32'(imem_req), 32'h0);
        chk_ifid("t3 hold", 32'hC, 32'h8, 1'b1);
        step(3);
        chk_ifid("t3 still hold", 32'hC, 32'h8, 1'b1);
        freeze = 1'b0;
        step(1);
        chk_ifid("t3 i12", 32'h10, 32'hC, 1'b1);
        chk("t3 addr16", imem_addr, 32'h10);

        // branch while frozen
        freeze = 1'b1; branch_taken = 1'b1; branch_address = 32'h103;
        step(1);
        freeze = 1'b0; branch_taken = 1'b0;
        chk_ifid("t4 flush", 32'h0, NOP, 1'b0);
        chk("t4 addr", imem_addr, 32'h100);
        step(1);
        chk_ifid("t4 i100", 32'h104, 32'h100, 1'b1);

        // branch while a request at 20 is waiting
        lat_addr = 32'h14; lat_val = 2;
        branch_taken = 1'b1; branch_address = 32'h14;
        step(1);
        chk("t5 addr20", imem_addr, 32'h14);
        branch_address = 32'h200;
        step(1);
        branch_taken = 1'b0;
        chk("t5 addr held a", imem_addr, 32'h14);
        chk("t5 valid a", 32'(valid_out), 32'h0);
        step(1);
        chk("t5 addr held b", imem_addr, 32'h14);
        step(1);
        chk("t5 addr200", imem_addr, 32'h200);
        chk_ifid("t5 dropped", 32'h0, NOP, 1'b0);
        step(1);
        chk_ifid("t5 i200", 32'h204, 32'h200, 1'b1);

        // wrap at top of address space, then async reset mid-wait
        branch_taken = 1'b1; branch_address = 32'hFFFF_FFFE;
        step(1);
        branch_taken = 1'b0;
        chk("t6 addr top", imem_addr, 32'hFFFF_FFFC);
        lat_addr = 32'h0; lat_val = 5;
        step(1);
        chk_ifid("t6 wrap", 32'h0, 32'hFFFF_FFFC, 1'b1);
        chk("t6 addr wrap", imem_addr, 32'h0);
        step(1);
        chk("t6 waiting req", 32'(imem_req), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_vals("t6 async reset");
        step(2);
        lat_val = 0;
        rst = 1'b1;
        step(1);
        chk("t6 restart req", 32'(imem_req), 32'h1);
        chk("t6 restart addr", imem_addr, 32'h0);
        step(1);
        chk_ifid("t6 restart i0", 32'h4, 32'h0, 1'b1);
        step(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
